// File: rtl/pe_wb_pkg.sv
// Shared types for the PE-array writeback stage: FSM encoding, lane word type,
// and the plane-size helper.
package pe_wb_pkg;

  localparam int WID_PE_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } wb_state_t;

  typedef logic signed [WID_PE_BITS-1:0] pe_word_t;

  // The product is taken at 32 bits so that a full 16x16 plane cannot overflow.
  function automatic logic [31:0] plane_total(input logic [15:0] row_len,
                                              input logic [15:0] rows);
    return 32'(row_len) * 32'(rows);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic first-word-fall-through synchronous FIFO. The head word is always
// visible on o_dout. A push while full is accepted only when a pop happens in the same cycle.
module wb_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage and wrap-bit pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_din;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pe_writeback.sv
// Writeback stage of the PE array. It collects the per-PE results into an FWFT skid FIFO
// and writes one N_PE-wide word per output pixel to linearly increasing addresses.
module pe_writeback
  import pe_wb_pkg::*;
#(
  parameter int N_PE   = 32,
  parameter int WID    = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [15:0]       i_out_row_length,
  input  logic [15:0]       i_out_rows,
  input  logic              i_in_valid,
  input  logic [WID-1:0]    i_in_data [N_PE],
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WID-1:0]    o_wr_data [N_PE],
  input  logic              i_wr_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  localparam int DW = N_PE * WID;

  wb_state_t         r_state;
  logic [15:0]       r_row_len;
  logic [15:0]       r_col;
  logic [15:0]       r_row;
  logic [31:0]       r_total;
  logic [31:0]       r_pushed;
  logic [31:0]       r_accepted;
  logic [31:0]       r_wc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;

  logic [DW-1:0]     w_din;
  logic [DW-1:0]     w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_push;
  logic              w_drop;
  logic [31:0]       w_pushed_next;
  logic [31:0]       w_wc_next;

  assign o_wr_en       = !w_empty;
  assign o_wr_addr     = r_wr_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overflow    = r_overflow;

  assign w_push        = i_in_valid && (r_state == RUN) && (r_pushed < r_total);
  assign w_pop         = o_wr_en && i_wr_ready;
  assign w_fifo_push   = w_push && (!w_full || w_pop);
  assign w_drop        = w_push && w_full && !w_pop;
  assign w_pushed_next = r_pushed + 32'(w_push);
  assign w_wc_next     = r_wc + 32'(w_pop);

  // Lane packing into and out of the FIFO word.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < N_PE; i++) begin
      w_din[i*WID +: WID] = i_in_data[i];
      o_wr_data[i]        = w_dout[i*WID +: WID];
    end
  end

  wb_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Plane sequencing, counters and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row_len  <= 16'd0;
      r_col      <= 16'd0;
      r_row      <= 16'd0;
      r_total    <= 32'd0;
      r_pushed   <= 32'd0;
      r_accepted <= 32'd0;
      r_wc       <= 32'd0;
      r_wr_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_pushed <= w_pushed_next;
      end
      if (w_fifo_push) begin
        r_accepted <= r_accepted + 32'd1;
      end
      // The row and column counters are kept only as a debug position.
      if (w_pop) begin
        r_wc      <= w_wc_next;
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        if (r_col == r_row_len - 16'd1) begin
          r_col <= 16'd0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_row_len  <= i_out_row_length;
            r_total    <= plane_total(i_out_row_length, i_out_rows);
            r_pushed   <= 32'd0;
            r_accepted <= 32'd0;
            r_wc       <= 32'd0;
            r_col      <= 16'd0;
            r_row      <= 16'd0;
            r_wr_addr  <= i_base_addr;
            r_overflow <= 1'b0;
            if ((i_out_row_length == 16'd0) || (i_out_rows == 16'd0)) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_pushed_next == r_total) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the same cycle as the last accepted write, not one cycle later.
          if (w_wc_next == r_accepted) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_writeback.sv
// Self-checking bench for pe_writeback. An independent FIFO-occupancy model
// feeds a scoreboard of expected {address, data} writes.
module tb_pe_writeback;
  import pe_wb_pkg::*;

  localparam int N_PE   = 4;
  localparam int WID    = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int DW     = N_PE * WID;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       row_len;
  logic [15:0]       rows;
  logic              valid;
  logic [WID-1:0]    in_data [N_PE];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WID-1:0]    wr_data [N_PE];
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [DW-1:0]     in_flat;
  logic [DW-1:0]     wr_flat;

  always #5 clk = ~clk;

  pe_writeback #(.N_PE(N_PE), .WID(WID), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_out_row_length(row_len), .i_out_rows(rows), .i_in_valid(valid),
    .i_in_data(in_data), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_wr_ready(wr_ready), .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );

  always_comb begin
    in_flat = '0;
    wr_flat = '0;
    for (int i = 0; i < N_PE; i++) begin
      in_flat[i*WID +: WID] = in_data[i];
      wr_flat[i*WID +: WID] = wr_data[i];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic              m_active = 1'b0;
  logic              m_ovf    = 1'b0;
  int                m_total  = 0;
  int                m_pushed = 0;
  logic [ADDR_W-1:0] m_addr   = '0;
  int wr_cnt, done_cnt, done_cyc, last_wr_cyc, tlast, start_cyc, stall_left;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DW-1:0]     prev_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_px(input int k);
    for (int i = 0; i < N_PE; i++) begin
      in_data[i] = WID'(16 * k + i);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("wr_en", wr_en, sb.size() > 0);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_active && !done && (m_total != 0));
    if (prev_stall && wr_en) begin
      chk("hold_addr", wr_addr, prev_addr);
      chk("hold_data", wr_flat, prev_data);
    end
    prev_stall = wr_en && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_flat;
    if (wr_en && wr_ready && (sb.size() > 0)) begin
      e = sb.pop_front();
      chk("wr_addr", wr_addr, e.addr);
      chk("wr_data", wr_flat, e.data);
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_active && valid && (m_pushed < m_total)) begin
      m_pushed++;
      if (sb.size() < DEPTH) begin
        e.addr = m_addr;
        e.data = in_flat;
        sb.push_back(e);
        m_addr++;
      end else begin
        m_ovf = 1'b1;
      end
      if (m_pushed == m_total) tlast = cyc;
    end
    if (start && !m_active) begin
      m_active  = 1'b1;
      m_total   = int'(row_len) * int'(rows);
      m_pushed  = 0;
      m_addr    = base_addr;
      m_ovf     = 1'b0;
      start_cyc = cyc;
    end else if (done) begin
      m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    wr_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  endtask

  // Start a plane and offer npush pixels back to back; restart_at fires a stray start.
  task automatic plane(input logic [ADDR_W-1:0] base, input int rl, input int nr,
                       input int stall, input int npush, input int restart_at);
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; tlast = -1;
    stall_left = stall;
    wr_ready   = (stall == 0);
    base_addr  = base;
    row_len    = 16'(rl);
    rows       = 16'(nr);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < npush; k++) begin
      valid = 1'b1;
      set_px(k);
      if (k == restart_at) begin
        start     = 1'b1;
        base_addr = 16'h1234;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while ((done_cnt == d0) && (n < budget)) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt != d0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; wr_ready = 1'b1; stall_left = 0;
    base_addr = '0; row_len = 16'd0; rows = 16'd0;
    set_px(0);
    #12;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0);
    chk("rst_wr_data", wr_flat, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Basic 2x3 plane at 0x100.
    plane(16'h0100, 2, 3, 0, 6, -1);
    wait_done(20);
    chk("basic_writes", wr_cnt, 6);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_last_wr", last_wr_cyc - tlast, 1);
    chk("basic_done_lat", done_cyc - tlast, 2);

    // Backpressure: 4x1 plane, buffer stalls for the first cycles.
    plane(16'h0200, 4, 1, 6, 4, -1);
    wait_done(30);
    chk("bp_writes", wr_cnt, 4);
    chk("bp_done_cnt", done_cnt, 1);

    // Overflow: 6x1 plane with the buffer stalled through all pushes.
    plane(16'h0300, 6, 1, 10, 6, -1);
    wait_done(30);
    chk("ovf_writes", wr_cnt, 4);
    chk("ovf_done_cnt", done_cnt, 1);
    chk("ovf_sticky", overflow, 1'b1);

    // Zero-size plane.
    plane(16'h0400, 3, 0, 0, 0, -1);
    wait_done(10);
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    chk("zero_writes", wr_cnt, 0);

    // Stray valid pulses in IDLE, then a wrapping plane with a second start mid-run.
    valid = 1'b1;
    set_px(99);
    tick();
    tick();
    valid = 1'b0;
    tick();
    plane(16'hFFFE, 1, 4, 0, 4, 1);
    wait_done(20);
    chk("wrap_writes", wr_cnt, 4);
    chk("wrap_done_cnt", done_cnt, 1);
    chk("wrap_end_addr", wr_addr, 16'h0002);

    // Reset during RUN with two entries queued.
    plane(16'h0500, 4, 1, 20, 2, -1);
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    sb.delete();
    m_active = 1'b0; m_ovf = 1'b0; m_total = 0; prev_stall = 1'b0;
    stall_left = 0;
    wr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_no_done", done_cnt, 0);
    plane(16'h0600, 2, 2, 0, 4, -1);
    wait_done(20);
    chk("post_rst_writes", wr_cnt, 4);
    chk("post_rst_done", done_cnt, 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
